halt_ctrl: RTL and testbench

Pipeline halt/resume controller. It owns the decode-stage enable (`id_en`): it raises `id_en` after a fixed boot delay following reset, and on request it stops issue, drains in-flight instructions, and reports a quiescent `halted` state. Releasing the request restarts issue. It sits beside the decode stage, fed by the issue and retire/commit strobes.

---
 rtl/halt_ctrl.sv | 160 ++++++++++++++++
 tb/tb_halt_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/halt_ctrl.sv
//------------------------------------------------------------------------------
// halt_ctrl : pipeline halt/resume controller owning the decode-stage enable.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module halt_ctrl #(
    parameter int BOOT_CYCLES   = 2,
    parameter int INFLIGHT_W    = 6,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt_req,
    input  logic                  issue_fire,
    input  logic                  retire_fire,
    input  logic                  flush,
    output logic                  id_en,
    output logic                  halted,
    output logic                  drain_timeout,
    output logic [INFLIGHT_W-1:0] inflight_cnt
);

    localparam int c_BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int c_TMR_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [c_BOOT_W-1:0]   c_BOOT_LAST = c_BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]    c_TMR_LAST  = c_TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [INFLIGHT_W-1:0] c_CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_HALTED = 3'd3,
        S_RESUME = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_id_en;
    logic                  w_id_en_nxt;
    logic                  r_halted;
    logic                  w_halted_nxt;
    logic                  r_dto;
    logic                  w_dto_nxt;
    logic [c_BOOT_W-1:0]   r_boot_cnt;
    logic [c_BOOT_W-1:0]   w_boot_nxt;
    logic [c_TMR_W-1:0]    r_timer;
    logic [c_TMR_W-1:0]    w_timer_nxt;
    logic [INFLIGHT_W-1:0] r_cnt;
    logic [INFLIGHT_W-1:0] w_cnt_nxt;
    logic                  w_inc;

    // Issues only count while decode is enabled; simultaneous issue+retire nets to zero.
    assign w_inc = issue_fire & r_id_en;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (flush) begin
            w_cnt_nxt = '0;
        end else if (w_inc && !retire_fire) begin
            if (r_cnt != c_CNT_MAX) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (!w_inc && retire_fire) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_id_en_nxt  = r_id_en;
        w_halted_nxt = r_halted;
        w_dto_nxt    = r_dto;
        w_boot_nxt   = r_boot_cnt;
        w_timer_nxt  = r_timer;
        case (r_state)
            S_BOOT: begin
                if (r_boot_cnt == c_BOOT_LAST) begin
                    if (halt_req) begin
                        w_state_nxt  = S_HALTED;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_id_en_nxt = 1'b1;
                    end
                end else begin
                    w_boot_nxt = r_boot_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    w_state_nxt = S_DRAIN;
                    w_id_en_nxt = 1'b0;
                    w_timer_nxt = '0;
                end
            end
            S_DRAIN: begin
                w_timer_nxt = r_timer + 1'b1;
                // Abort beats completion, completion beats timeout.
                if (!halt_req) begin
                    w_state_nxt = S_RUN;
                    w_id_en_nxt = 1'b1;
                end else if (w_cnt_nxt == '0) begin
                    w_state_nxt  = S_HALTED;
                    w_halted_nxt = 1'b1;
                end else if (r_timer == c_TMR_LAST) begin
                    w_state_nxt  = S_HALTED;
                    w_halted_nxt = 1'b1;
                    w_dto_nxt    = 1'b1;
                end
            end
            S_HALTED: begin
                if (!halt_req) begin
                    w_state_nxt  = S_RESUME;
                    w_halted_nxt = 1'b0;
                end
            end
            S_RESUME: begin
                w_state_nxt = S_RUN;
                w_id_en_nxt = 1'b1;
            end
            default: begin
                w_state_nxt  = S_BOOT;
                w_id_en_nxt  = 1'b0;
                w_halted_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_BOOT;
            r_id_en    <= 1'b0;
            r_halted   <= 1'b0;
            r_dto      <= 1'b0;
            r_boot_cnt <= '0;
            r_timer    <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_id_en    <= w_id_en_nxt;
            r_halted   <= w_halted_nxt;
            r_dto      <= w_dto_nxt;
            r_boot_cnt <= w_boot_nxt;
            r_timer    <= w_timer_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign id_en         = r_id_en;
    assign halted        = r_halted;
    assign drain_timeout = r_dto;
    assign inflight_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_halt_ctrl.sv
//------------------------------------------------------------------------------
// tb_halt_ctrl : directed self-checking bench for halt_ctrl (DRAIN_TIMEOUT=8).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_halt_ctrl;

    logic       clk;
    logic       rst;
    logic       halt_req;
    logic       issue_fire;
    logic       retire_fire;
    logic       flush;
    logic       id_en;
    logic       halted;
    logic       drain_timeout;
    logic [5:0] inflight_cnt;

    int n_cmp;
    int n_err;

    halt_ctrl #(
        .BOOT_CYCLES   (2),
        .INFLIGHT_W    (6),
        .DRAIN_TIMEOUT (8)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .halt_req      (halt_req),
        .issue_fire    (issue_fire),
        .retire_fire   (retire_fire),
        .flush         (flush),
        .id_en         (id_en),
        .halted        (halted),
        .drain_timeout (drain_timeout),
        .inflight_cnt  (inflight_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic e_id, input logic e_h,
                           input logic e_dto, input int e_cnt);
        chk({tag, ".id_en"}, 32'(id_en), 32'(e_id));
        chk({tag, ".halted"}, 32'(halted), 32'(e_h));
        chk({tag, ".dto"}, 32'(drain_timeout), 32'(e_dto));
        chk({tag, ".cnt"}, 32'(inflight_cnt), 32'(e_cnt));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0; halt_req = 1'b0; issue_fire = 1'b0; retire_fire = 1'b0; flush = 1'b0;

        // Reset and boot
        tick(2);
        chk_out("reset", 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk_out("boot_e1", 0, 0, 0, 0);
        tick();
        chk_out("boot_e2", 1, 0, 0, 0);

        // Three issues then drain with three retires
        issue_fire = 1'b1;
        tick(3);
        issue_fire = 1'b0;
        chk_out("issue3", 1, 0, 0, 3);
        halt_req = 1'b1;
        tick();
        chk_out("drain_entry", 0, 0, 0, 3);
        retire_fire = 1'b1;
        tick();
        chk_out("retire1", 0, 0, 0, 2);
        tick();
        chk_out("retire2", 0, 0, 0, 1);
        tick();
        chk_out("retire3_halt", 0, 1, 0, 0);
        retire_fire = 1'b0;

        // Issue with id_en low, retire at zero
        issue_fire = 1'b1;
        tick();
        issue_fire = 1'b0;
        chk_out("issue_gated", 0, 1, 0, 0);
        retire_fire = 1'b1;
        tick();
        retire_fire = 1'b0;
        chk_out("retire_at0", 0, 1, 0, 0);

        // Resume
        halt_req = 1'b0;
        tick();
        chk_out("resume_e1", 0, 0, 0, 0);
        tick();
        chk_out("resume_e2", 1, 0, 0, 0);
        issue_fire = 1'b1;
        tick();
        chk_out("post_resume_issue", 1, 0, 0, 1);

        // Flush collides with issue at count 5
        tick(4);
        chk_out("cnt5", 1, 0, 0, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_out("flush_issue", 1, 0, 0, 0);

        // Saturation: 70 issues
        tick(70);
        issue_fire = 1'b0;
        chk_out("saturate", 1, 0, 0, 63);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_out("flush_sat", 1, 0, 0, 0);

        // Timeout: issue counted on the halt edge, no retires
        issue_fire = 1'b1;
        tick();
        halt_req = 1'b1;
        tick();
        issue_fire = 1'b0;
        chk_out("to_entry", 0, 0, 0, 2);
        tick(7);
        chk_out("to_edge7", 0, 0, 0, 2);
        tick();
        chk_out("to_edge8", 0, 1, 1, 2);
        halt_req = 1'b0;
        tick(2);
        chk_out("to_resume", 1, 0, 1, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Abort mid-drain
        halt_req = 1'b1;
        issue_fire = 1'b1;
        tick();
        issue_fire = 1'b0;
        chk_out("abort_entry", 0, 0, 1, 1);
        tick();
        chk_out("abort_drain", 0, 0, 1, 1);
        halt_req = 1'b0;
        tick();
        chk_out("abort_run", 1, 0, 1, 1);

        // Asynchronous reset mid-drain
        halt_req = 1'b1;
        tick();
        chk_out("rst_pre", 0, 0, 1, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_out("rst_async", 0, 0, 0, 0);

        // halt_req held through boot
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk_out("boot_halt_e1", 0, 0, 0, 0);
        tick();
        chk_out("boot_halt_e2", 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
